// File: rtl/rr_arb8.sv
// rr_arb8: 8-way round-robin arbiter with registered one-hot grant and index.
// The grant is held until the owner pulses done or drops its request. At least
// one idle cycle separates any two grants.
// Optional feature (macro HOLD_TIMEOUT_EN): a grant is forcibly released after
// MAX_HOLD cycles, and tmo pulses for the one cycle that follows the release.
module rr_arb8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic       tmo
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Reject hold limits outside the supported range at elaboration.
  if ((MAX_HOLD < 2) || (MAX_HOLD > 256)) begin : g_max_hold_range
    $error("rr_arb8: MAX_HOLD must lie in 2..256");
  end

  state_t     state_r, state_s;
  logic [2:0] ptr_r, ptr_s;
  logic [7:0] gnt_s;
  logic [2:0] idx_s;
  logic       vld_s;
  logic       tmo_s;
  logic       release_s;

`ifdef HOLD_TIMEOUT_EN
  localparam int                HOLD_W    = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_s;
`endif

  // Return the first set request found when scanning upward from start, with
  // wrap-around. The caller guarantees that r is non-zero.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] start);
    logic [2:0] cand;
    logic       found;
    logic [2:0] sel;
    sel   = start;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cand = start + 3'(i);
      if (!found && r[cand]) begin
        sel   = cand;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return sel;
  endfunction

  // Next-state and next-output logic. Every register holds its value unless a
  // transition below changes it.
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    gnt_s     = gnt;
    idx_s     = gnt_idx;
    vld_s     = gnt_vld;
    tmo_s     = 1'b0;
    release_s = done | ~req[gnt_idx];
`ifdef HOLD_TIMEOUT_EN
    hold_cnt_s = hold_cnt_r;
`endif
    case (state_r)
      IDLE: begin
        if (req != 8'h00) begin
          idx_s   = rr_pick(req, ptr_r);
          gnt_s   = 8'h01 << idx_s;
          vld_s   = 1'b1;
          state_s = GRANT;
`ifdef HOLD_TIMEOUT_EN
          hold_cnt_s = '0;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        if (release_s) begin
          gnt_s   = 8'h00;
          vld_s   = 1'b0;
          ptr_s   = gnt_idx + 3'd1;
          state_s = IDLE;
`ifdef HOLD_TIMEOUT_EN
        end else if (hold_cnt_r == HOLD_LAST) begin
          // Forced release: the pointer still moves past the owner.
          gnt_s   = 8'h00;
          vld_s   = 1'b0;
          ptr_s   = gnt_idx + 3'd1;
          tmo_s   = 1'b1;
          state_s = IDLE;
        end else begin
          hold_cnt_s = hold_cnt_r + HOLD_W'(1);
        end
`else
        end else begin
          state_s = GRANT;
        end
`endif
      end
      default: begin
        state_s = IDLE;
        gnt_s   = 8'h00;
        vld_s   = 1'b0;
      end
    endcase
  end

  // State and output registers, with a synchronous reset that overrides everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      ptr_r   <= 3'd0;
      gnt     <= 8'h00;
      gnt_idx <= 3'd0;
      gnt_vld <= 1'b0;
      tmo     <= 1'b0;
`ifdef HOLD_TIMEOUT_EN
      hold_cnt_r <= '0;
`endif
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      gnt     <= gnt_s;
      gnt_idx <= idx_s;
      gnt_vld <= vld_s;
      tmo     <= tmo_s;
`ifdef HOLD_TIMEOUT_EN
      hold_cnt_r <= hold_cnt_s;
`endif
    end
  end

endmodule

// File: tb/tb_rr_arb8.sv
// tb_rr_arb8: directed, self-checking bench for rr_arb8 using a scoreboard queue.
// Each step drives the inputs and pushes the outputs expected after the next
// clock edge. After that edge the expectation is popped and compared.
module tb_rr_arb8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       tmo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [2:0] idx;
    logic       vld;
    logic       tmo;
  } exp_t;

  exp_t sb[$];

  rr_arb8 #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .tmo     (tmo)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Drive the inputs for one edge, queue the expected outputs, then compare after the edge.
  task automatic step(input string tag, input logic r, input logic [7:0] q, input logic d,
                      input logic [2:0] ei, input logic ev, input logic et);
    exp_t e;
    logic [7:0] eg;
    rst  = r;
    req  = q;
    done = d;
    sb.push_back('{tag, ei, ev, et});
    @(posedge clk);
    #1;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e  = sb.pop_front();
      eg = e.vld ? (8'h01 << e.idx) : 8'h00;
      chk({e.tag, "_gnt"}, gnt, eg);
      chk({e.tag, "_idx"}, {5'd0, gnt_idx}, {5'd0, e.idx});
      chk({e.tag, "_vld"}, {7'd0, gnt_vld}, {7'd0, e.vld});
      chk({e.tag, "_tmo"}, {7'd0, tmo}, {7'd0, e.tmo});
    end
  endtask

  initial begin
    rst  = 1'b1;
    req  = 8'hFF;
    done = 1'b0;

    // Reset with all requesters active, then the first grant goes to index 0.
    step("rst0", 1'b1, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b0);
    step("rst1", 1'b1, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b0);
    step("first", 1'b0, 8'hFF, 1'b0, 3'd0, 1'b1, 1'b0);
    step("rel0", 1'b0, 8'hFF, 1'b1, 3'd0, 1'b0, 1'b0);

    // Rotation: 1..7 then 0, with one idle cycle after every release.
    for (int k = 1; k <= 8; k++) begin
      step($sformatf("rot%0d", k), 1'b0, 8'hFF, 1'b0, 3'(k % 8), 1'b1, 1'b0);
      step($sformatf("rotrel%0d", k), 1'b0, 8'hFF, 1'b1, 3'(k % 8), 1'b0, 1'b0);
    end

    // Wrap search: the pointer is at 1, so 7 wins, then the search wraps to 0.
    step("wrap7", 1'b0, 8'h81, 1'b0, 3'd7, 1'b1, 1'b0);
    step("wrap7rel", 1'b0, 8'h81, 1'b1, 3'd7, 1'b0, 1'b0);
    step("wrap0", 1'b0, 8'h81, 1'b0, 3'd0, 1'b1, 1'b0);
    step("wrap0rel", 1'b0, 8'h81, 1'b1, 3'd0, 1'b0, 1'b0);

    // A late arrival is ignored while granted. Dropping the owner's request releases it.
    step("drop2", 1'b0, 8'h04, 1'b0, 3'd2, 1'b1, 1'b0);
    step("late1a", 1'b0, 8'h06, 1'b0, 3'd2, 1'b1, 1'b0);
    step("late1b", 1'b0, 8'h06, 1'b0, 3'd2, 1'b1, 1'b0);
    step("droprel", 1'b0, 8'h02, 1'b0, 3'd2, 1'b0, 1'b0);
    step("grant1", 1'b0, 8'h02, 1'b0, 3'd1, 1'b1, 1'b0);
    step("rel1", 1'b0, 8'h00, 1'b0, 3'd1, 1'b0, 1'b0);
    step("idle", 1'b0, 8'h00, 1'b0, 3'd1, 1'b0, 1'b0);
    step("idledone", 1'b0, 8'h00, 1'b1, 3'd1, 1'b0, 1'b0);

    // Reset in the middle of a grant clears the pointer, so index 4 wins again.
    step("g4", 1'b0, 8'h10, 1'b0, 3'd4, 1'b1, 1'b0);
    step("g4hold", 1'b0, 8'h10, 1'b0, 3'd4, 1'b1, 1'b0);
    step("midrst", 1'b1, 8'h10, 1'b1, 3'd0, 1'b0, 1'b0);
    step("g4again", 1'b0, 8'h10, 1'b0, 3'd4, 1'b1, 1'b0);

    // done together with a request drop is one release, so the pointer moves to 5.
    step("dualrel", 1'b0, 8'h00, 1'b1, 3'd4, 1'b0, 1'b0);
    step("g5", 1'b0, 8'h21, 1'b0, 3'd5, 1'b1, 1'b0);
    step("g5rel", 1'b0, 8'h21, 1'b1, 3'd5, 1'b0, 1'b0);

    // Hold behaviour with MAX_HOLD=4. The pointer is at 6, so index 0 wins.
    step("h0", 1'b0, 8'h03, 1'b0, 3'd0, 1'b1, 1'b0);
`ifdef HOLD_TIMEOUT_EN
    step("h0c1", 1'b0, 8'h03, 1'b0, 3'd0, 1'b1, 1'b0);
    step("h0c2", 1'b0, 8'h03, 1'b0, 3'd0, 1'b1, 1'b0);
    step("h0c3", 1'b0, 8'h03, 1'b0, 3'd0, 1'b1, 1'b0);
    step("tmo0", 1'b0, 8'h03, 1'b0, 3'd0, 1'b0, 1'b1);
    step("h1", 1'b0, 8'h03, 1'b0, 3'd1, 1'b1, 1'b0);
    step("h1c1", 1'b0, 8'h03, 1'b0, 3'd1, 1'b1, 1'b0);
    step("h1c2", 1'b0, 8'h03, 1'b0, 3'd1, 1'b1, 1'b0);
    step("h1c3", 1'b0, 8'h03, 1'b0, 3'd1, 1'b1, 1'b0);
    step("h1donetmo", 1'b0, 8'h03, 1'b1, 3'd1, 1'b0, 1'b0);
`else
    for (int k = 1; k <= 8; k++) begin
      step($sformatf("h0hold%0d", k), 1'b0, 8'h03, 1'b0, 3'd0, 1'b1, 1'b0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
